// File: rtl/shift_rows_stream.sv
// Streaming AES ShiftRows: bytes in, permuted bytes out.
// Two 16-byte banks let one block fill while the other drains.
module shift_rows_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready
);

    logic [7:0] mem [2][16];
    logic [1:0] full;
    logic       wbank;
    logic       rbank;
    logic [3:0] widx;
    logic [3:0] ridx;
    logic [3:0] src_idx;
    logic [1:0] set_full;
    logic [1:0] clr_full;
    logic       in_fire;
    logic       out_fire;

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign out_last  = out_valid && (ridx == 4'd15);
    assign out_data  = mem[rbank][src_idx];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Output byte j reads input byte P(j): row stays, column shifts by row.
    always_comb begin
        unique case (ridx)
            4'd0:  src_idx = 4'd0;
            4'd1:  src_idx = 4'd5;
            4'd2:  src_idx = 4'd10;
            4'd3:  src_idx = 4'd15;
            4'd4:  src_idx = 4'd4;
            4'd5:  src_idx = 4'd9;
            4'd6:  src_idx = 4'd14;
            4'd7:  src_idx = 4'd3;
            4'd8:  src_idx = 4'd8;
            4'd9:  src_idx = 4'd13;
            4'd10: src_idx = 4'd2;
            4'd11: src_idx = 4'd7;
            4'd12: src_idx = 4'd12;
            4'd13: src_idx = 4'd1;
            4'd14: src_idx = 4'd6;
            4'd15: src_idx = 4'd11;
        endcase
    end

    always_comb begin
        set_full = 2'b00;
        clr_full = 2'b00;
        if (in_fire && (widx == 4'd15)) begin
            set_full[wbank] = 1'b1;
        end
        if (out_fire && (ridx == 4'd15)) begin
            clr_full[rbank] = 1'b1;
        end
    end

    // Set and clear always target different banks, so both can land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 2'b00;
            wbank <= 1'b0;
            rbank <= 1'b0;
            widx  <= 4'd0;
            ridx  <= 4'd0;
        end else begin
            full <= (full | set_full) & ~clr_full;
            if (in_fire) begin
                widx <= widx + 4'd1;
                if (widx == 4'd15) begin
                    wbank <= ~wbank;
                end
            end
            if (out_fire) begin
                ridx <= ridx + 4'd1;
                if (ridx == 4'd15) begin
                    rbank <= ~rbank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_fire) begin
            mem[wbank][widx] <= in_data;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream.
// Scoreboard of expected {last,data} beats fed by the stimulus side.
`timescale 1ns/1ps
module tb_shift_rows_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;
    int acc_count = 0;
    bit rand_rdy = 0;

    logic [8:0] sb [$];
    int perm_tbl [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    logic       hold_v = 0;
    logic [7:0] hold_d;
    logic       hold_l;

    shift_rows_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares every transferred beat and stall stability.
    initial begin
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    check("stall_hold", {22'd0, out_valid, out_last, out_data},
                          {22'd0, 1'b1, hold_l, hold_d});
                end
                if (out_valid && out_ready) begin
                    check("out_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (sb.size() > 0) begin
                        exp = sb.pop_front();
                        check("out_beat", {23'd0, out_last, out_data}, {23'd0, exp});
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
                hold_l = out_last;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  acc;
        n   = 0;
        acc = 0;
        in_valid = 1;
        in_data  = b;
        while (!acc && n < 2000) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        if (acc) begin
            acc_count++;
        end else begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=stalled expected=accepted");
        end
        in_valid = 0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_block(input logic [127:0] blk, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send_byte(blk[127-8*i -: 8]);
        end
        for (int j = 0; j < 16; j++) begin
            sb.push_back({(j == 15), blk[127-8*perm_tbl[j] -: 8]});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_valid", {31'd0, out_valid}, 0);
    endtask

    task automatic pulse_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        sb.delete();
    endtask

    initial begin
        logic [127:0] blk;
        int n;
        rst       = 1;
        in_valid  = 0;
        in_data   = 0;
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);

        // Counting block, latency of first output byte.
        out_ready = 1;
        send_block(128'h000102030405060708090a0b0c0d0e0f, 0);
        @(negedge clk);
        check("latency_valid", {31'd0, out_valid}, 1);
        check("latency_data", {24'd0, out_data}, 32'h00);
        @(posedge clk);
        #1;
        drain();

        // FIPS-197 round-1 state.
        send_block(128'hd42711aee0bf98f1b8b45de51e415230, 0);
        drain();

        // Three blocks back-to-back against a stalled sink.
        out_ready = 0;
        acc_count = 0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    send_block({$urandom, $urandom, $urandom, $urandom}, 0);
                end
            end
            begin
                n = 0;
                while (acc_count < 32 && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                repeat (5) @(posedge clk);
                #1;
                check("full_accepted", acc_count, 32);
                check("full_in_ready", {31'd0, in_ready}, 0);
                out_ready = 1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(out_valid && out_ready && out_last) && n < 100);
                check("pre_free_in_ready", {31'd0, in_ready}, 0);
                @(posedge clk);
                #1;
                check("post_free_in_ready", {31'd0, in_ready}, 1);
            end
        join
        drain();

        // Partial block then reset: only the fresh block comes out.
        for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i));
        repeat (3) @(posedge clk);
        #1;
        check("partial_no_valid", {31'd0, out_valid}, 0);
        pulse_reset();
        check("rst_mid_in_ready", {31'd0, in_ready}, 1);
        send_block(128'h000102030405060708090a0b0c0d0e0f, 0);
        drain();

        // Reset while a block is half drained, with a competing input beat.
        out_ready = 0;
        send_block({$urandom, $urandom, $urandom, $urandom}, 0);
        out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 0;
        in_valid  = 1;
        in_data   = 8'hAA;
        pulse_reset();
        in_valid = 0;
        check("rst_out_valid2", {31'd0, out_valid}, 0);
        check("rst_in_ready2", {31'd0, in_ready}, 1);
        check("rst_out_last2", {31'd0, out_last}, 0);
        out_ready = 1;
        send_block(128'h0f0e0d0c0b0a09080706050403020100, 0);
        drain();

        // Random valid/ready traffic.
        rand_rdy = 1;
        for (int k = 0; k < 1000; k++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            send_block(blk, 1);
        end
        drain();
        rand_rdy = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

Interface
REQ-001 Parameters: none; byte width 8, block size 16 bytes, bank count 2, all fixed.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port in_valid  input  1  in_data holds a valid state byte.
REQ-005 Port in_data  input  8  state byte, block byte index 0 first.
REQ-006 Port in_ready  output  1  block can accept a byte this cycle.
REQ-007 Port out_valid  output  1  out_data holds a valid permuted byte.
REQ-008 Port out_data  output  8  ShiftRows-permuted byte, output index 0 first.
REQ-009 Port out_last  output  1  high with output byte index 15.
REQ-010 Port out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-011 Byte index i of a 128-bit state maps to S[127-8i -: 8], so byte 0 is the MSB byte; row = i mod 4, column = i div 4.
REQ-012 Forward ShiftRows: output byte (r,c) SHALL equal input byte (r,(c+r) mod 4); output index j takes input index P(j) = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11 for j = 0..15.
REQ-013 An input beat transfers when in_valid and in_ready are both high; an output beat transfers when out_valid and out_ready are both high.
REQ-014 Storage: two 16-byte banks, each with a full flag, plus a write-bank pointer, a read-bank pointer, a 4-bit write index and a 4-bit read index.
REQ-015 Write side: an accepted byte is stored at bank[wbank][widx] and widx increments; when widx=15 is accepted, full[wbank] sets, widx wraps to 0 and wbank toggles.
REQ-016 in_ready = !full[wbank]; it is a function of registered state only, with no combinational path from out_ready or in_valid.
REQ-017 Read side: out_valid = full[rbank]; out_data = bank[rbank][P(ridx)]; out_last = out_valid and ridx=15.
REQ-018 On an accepted output beat ridx increments; when ridx=15 is accepted, full[rbank] clears, ridx wraps to 0 and rbank toggles.
REQ-019 Latency: the first output byte is valid in the cycle after the 16th input byte is accepted.
REQ-020 Throughput: with in_valid and out_ready held high, one byte per cycle in steady state with no bubbles between blocks.
REQ-021 Simultaneous completion of a write and a read in the same cycle on different banks: both flag updates take effect.
REQ-022 When both banks are full, in_ready is low; the cycle after the last byte of the older block is accepted, in_ready goes high.
REQ-023 If out_ready is low while out_valid is high, out_data, out_last and ridx hold stable.
REQ-024 A partial block (fewer than 16 bytes accepted) never drives out_valid; it waits indefinitely for its remaining bytes.
REQ-025 Bytes presented while in_ready is low are ignored, and widx is unchanged.

Reset
REQ-026 While rst is high, the next edge clears both full flags, wbank, rbank, widx and ridx to 0.
REQ-027 After reset: out_valid=0, out_last=0, in_ready=1; out_data is don't-care while out_valid=0.
REQ-028 Reset mid-block discards all buffered and partial data; bank contents need not be cleared.
REQ-029 Reset has priority over any simultaneous handshake in the same cycle.

Verification
REQ-030 Input bytes 0x00..0x0F with out_ready=1 -> output 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B; out_last only on 0B; first output one cycle after byte 0F is accepted.
REQ-031 FIPS-197 round-1 state d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
REQ-032 Three blocks streamed back-to-back with out_ready=0 -> in_ready drops after 32 bytes accepted; on releasing out_ready, all 48 bytes emerge correctly in order, and in_ready rises one cycle after the 16th output byte.
REQ-033 Random in_valid/out_ready toggling over 1000 random blocks -> output matches a reference model, no byte lost or duplicated, and out_data stable while stalled.
REQ-034 rst asserted after 7 input bytes, then a fresh block 0x00..0x0F -> only the fresh block's permutation is output.
REQ-035 rst asserted with one block full and mid-output -> out_valid=0 and in_ready=1 on the next cycle.
